// File: rtl/rvv_backend_rs_fifo.sv
// Reservation-station entry buffer: multi-slot push from dispatch, multi-slot
// in-order pop to the execution unit issue logic.
module rvv_backend_rs_fifo #(
  parameter int  DEPTH        = 8,
  parameter type DATA_T       = logic [63:0],
  parameter int  PUSH_N       = 2,
  parameter int  POP_N        = 2,
  parameter bit  PROTOCOL_CHK = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [PUSH_N-1:0]      push_valid,
  input  DATA_T                  push_data [PUSH_N],
  output logic [PUSH_N-1:0]      push_ready,
  output logic [POP_N-1:0]       pop_valid,
  output DATA_T                  pop_data [POP_N],
  input  logic [POP_N-1:0]       pop_ready,
  output logic [$clog2(DEPTH):0] entry_cnt,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] free_cnt;
  logic [PW-1:0] push_cnt;
  logic [PW-1:0] pop_cnt;
  logic          push_run;
  logic          pop_run;
  DATA_T         mem_q [DEPTH];

  function automatic logic [AW-1:0] slot_idx(input logic [PW-1:0] ptr, input int off);
    logic [PW-1:0] sum;
    sum = ptr + PW'(off);
    return sum[AW-1:0];
  endfunction

  assign entry_cnt = wptr_q - rptr_q;
  assign free_cnt  = PW'(DEPTH) - entry_cnt;
  assign full      = (entry_cnt == PW'(DEPTH));
  assign empty     = (entry_cnt == '0);

  // Readiness is derived from registered occupancy only; same-cycle pops are not credited.
  always_comb begin
    push_ready = '0;
    for (int i = 0; i < PUSH_N; i++) begin
      push_ready[i] = (free_cnt > PW'(i));
    end
  end

  always_comb begin
    pop_valid = '0;
    for (int j = 0; j < POP_N; j++) begin
      pop_valid[j] = (entry_cnt > PW'(j));
      pop_data[j]  = mem_q[slot_idx(rptr_q, j)];
    end
  end

  // Only the leading run of accepted slots counts; anything after a gap is ignored.
  always_comb begin
    push_cnt = '0;
    push_run = 1'b1;
    for (int i = 0; i < PUSH_N; i++) begin
      push_run = push_run & push_valid[i] & push_ready[i];
      if (push_run) push_cnt = push_cnt + PW'(1);
    end
  end

  always_comb begin
    pop_cnt = '0;
    pop_run = 1'b1;
    for (int j = 0; j < POP_N; j++) begin
      pop_run = pop_run & pop_valid[j] & pop_ready[j];
      if (pop_run) pop_cnt = pop_cnt + PW'(1);
    end
  end

  always_comb begin
    wptr_d = wptr_q + push_cnt;
    rptr_d = rptr_q + pop_cnt;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Payload storage is never cleared; the pointers alone define what is live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < PUSH_N; i++) begin
      if (rst_n && !flush && (PW'(i) < push_cnt)) begin
        mem_q[slot_idx(wptr_q, i)] <= push_data[i];
      end
    end
  end

  a_push_within_room: assert property (@(posedge clk) disable iff (!rst_n)
    push_cnt <= free_cnt);

  a_cnt_bounded: assert property (@(posedge clk) disable iff (!rst_n)
    entry_cnt <= PW'(DEPTH));

  generate
    if (PROTOCOL_CHK) begin : g_proto
      logic [PUSH_N-1:0] push_valid_inc;
      logic [POP_N-1:0]  pop_ready_inc;
      assign push_valid_inc = push_valid + PUSH_N'(1);
      assign pop_ready_inc  = pop_ready + POP_N'(1);

      a_push_prefix: assert property (@(posedge clk) disable iff (!rst_n)
        (push_valid & push_valid_inc) == '0);

      a_pop_prefix: assert property (@(posedge clk) disable iff (!rst_n)
        (pop_ready & pop_ready_inc) == '0);
    end
  endgenerate

endmodule
